banana_motion_ctrl: RTL and testbench
=====================================

Name: banana_motion_ctrl

Overview:
- Drives the falling banana object: produces the top-left position and the appear gate consumed by the banana bitmap drawer.
- Consumes that drawer's per-pixel collision result and 4-bit HitEdgeCode to decide when the banana is caught.
- Sits between the game controller (launch command, frame timing) and the banana square/bitmap pair in the VGA object chain.
- Updates once per frame with gravity, and retires the banana on catch or floor exit.

Parameters:
- FIXED_POINT_MULT, 64, sub-pixel scale for position and speed (power of 2; divide is a right shift).
- START_Y, 32, pixel row where a launched banana appears.
- FLOOR_Y, 448, pixel row; reaching or passing it ends the fall as a miss.
- INIT_SPEED, 40, initial Y speed in fixed-point units per frame.
- GRAVITY, 4, Y speed increment per frame.
- MAX_SPEED, 320, Y speed saturation value.
- HIT_FRAMES, 8, frames the banana stays visible after a catch.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- launch  in  1  one-cycle request to drop a banana.
- launchX  in  11  pixel column for the launch.
- collision  in  1  banana pixel overlaps the player this cycle (already qualified by drawingRequest).
- HitEdgeCode  in  4  edge code of the colliding pixel: bit3 left, bit2 top, bit1 right, bit0 bottom.
- topLeftX  out  11  banana column in pixels.
- topLeftY  out  11  banana row in pixels.
- appear  out  1  banana visible.
- busy  out  1  state is not IDLE.
- caught  out  1  one-cycle pulse on catch.
- missed  out  1  one-cycle pulse on floor exit.

Behaviour:
- Reset and clocking: resetN is asynchronous, active-low; clock is clk. Reset forces:
  - state IDLE; internal X, Y, speed = 0; hit_flag = 0; edge_acc = 0; frame counter = 0.
  - all outputs 0.
- Reset mid-fall aborts immediately: appear goes to 0 with no caught or missed pulse.
- Internal arithmetic:
  - X, Y and Yspeed are signed 32-bit fixed-point values.
  - topLeftX = X >>> log2(FIXED_POINT_MULT) and topLeftY = Y >>> log2(FIXED_POINT_MULT), truncated to 11 bits, registered.
- States: IDLE, FALL, HIT.
- IDLE:
  - appear = 0.
  - launch = 1 → next cycle: X = launchX*FIXED_POINT_MULT, Y = START_Y*FIXED_POINT_MULT, Yspeed = INIT_SPEED, hit_flag = 0, edge_acc = 0, state FALL, appear = 1.
  - launch in any other state is ignored.
- FALL, any cycle: collision = 1 and HitEdgeCode != 0 → hit_flag = 1 and edge_acc |= HitEdgeCode.
- FALL, on startOfFrame, evaluated in priority order:
  1. hit_flag = 1 and edge_acc[2] or edge_acc[0] set (top or bottom edge touched) → state HIT, caught pulse, frame counter = 0, position frozen.
  2. hit_flag = 1 with only side edges touched → Yspeed = 0, then step 4; hit_flag and edge_acc are cleared.
  3. Y + Yspeed ≥ FLOOR_Y*FIXED_POINT_MULT → state IDLE, appear = 0, missed pulse.
  4. Otherwise: Y += Yspeed; Yspeed = min(Yspeed + GRAVITY, MAX_SPEED).
- A collision arriving on the same cycle as startOfFrame is not part of that evaluation; it is latched for the next frame.
- HIT:
  - appear = 1; frame counter increments on each startOfFrame.
  - When the counter reaches HIT_FRAMES-1 at a startOfFrame → IDLE, appear = 0.
  - collision input is ignored.
- Latency:
  - Position outputs change one clk after startOfFrame.
  - caught and missed assert one clk after the evaluating startOfFrame, for exactly one cycle.
- busy = (state != IDLE), registered together with the state.

Test Plan:
- Reset, then launch with launchX=100 → next cycle topLeftX=100, topLeftY=32, appear=1, busy=1.
- Free fall, no collision, 3 frames → topLeftY steps: 32 → 32 (Y=2088) → 33 (Y=2132) → 34 (Y=2180); Yspeed reaches 52.
- collision with HitEdgeCode=4'h4 mid-frame → next startOfFrame: caught pulses 1 cycle, position frozen; appear stays 1 for 8 frames, then 0, busy=0.
- collision with HitEdgeCode=4'h8 only → no caught; Y unchanged that frame; speed restarts from 0+GRAVITY.
- Fall to FLOOR_Y with no collision → missed pulses once, appear=0, state IDLE; a launch during the fall is ignored and a launch after the miss is accepted.
- resetN low during FALL → outputs 0 asynchronously, no pulses; collision coincident with startOfFrame → catch occurs one frame later.

Source files
------------

// File: rtl/banana_motion_ctrl.sv
// Falling banana: launch, per-frame gravity, edge-qualified catch, floor miss.
// Position kept in signed fixed point; pixel outputs are its integer part.
module banana_motion_ctrl #(
  parameter int FIXED_POINT_MULT = 64,
  parameter int START_Y          = 32,
  parameter int FLOOR_Y          = 448,
  parameter int INIT_SPEED       = 40,
  parameter int GRAVITY          = 4,
  parameter int MAX_SPEED        = 320,
  parameter int HIT_FRAMES       = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        launch,
  input  logic [10:0] launchX,
  input  logic        collision,
  input  logic [3:0]  HitEdgeCode,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        appear,
  output logic        busy,
  output logic        caught,
  output logic        missed
);

  localparam int SH = $clog2(FIXED_POINT_MULT);
  localparam int CW = $clog2(HIT_FRAMES) + 1;

  localparam logic signed [31:0] L_START =
    32'(START_Y * FIXED_POINT_MULT);
  localparam logic signed [31:0] L_FLOOR =
    32'(FLOOR_Y * FIXED_POINT_MULT);
  localparam logic signed [31:0] L_INIT = 32'(INIT_SPEED);
  localparam logic signed [31:0] L_GRAV = 32'(GRAVITY);
  localparam logic signed [31:0] L_MAX  = 32'(MAX_SPEED);
  localparam logic [CW-1:0]      L_LAST = CW'(HIT_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FALL,
    HIT
  } state_t;

  state_t             r_state;
  logic signed [31:0] r_x;
  logic signed [31:0] r_y;
  logic signed [31:0] r_spd;
  logic               r_hit;
  logic [3:0]         r_acc;
  logic [CW-1:0]      r_cnt;

  logic               w_hit_now;
  logic               w_vert;
  logic               w_side;
  logic               w_floor;
  logic signed [31:0] w_spd_base;
  logic signed [31:0] w_spd_inc;
  logic signed [31:0] w_spd_sat;
  logic signed [31:0] w_y_sum;
  logic signed [31:0] w_x_fp;
  logic signed [31:0] w_x_px;
  logic signed [31:0] w_y_px;
  logic               w_unused;

  assign w_hit_now  = collision && (HitEdgeCode != 4'h0);
  assign w_vert     = r_acc[2] | r_acc[0];
  assign w_side     = r_hit && !w_vert;
  // A side-only touch stalls the fall: speed restarts from zero.
  assign w_spd_base = w_side ? 32'sd0 : r_spd;
  assign w_y_sum    = r_y + w_spd_base;
  assign w_spd_inc  = w_spd_base + L_GRAV;
  assign w_spd_sat  = (w_spd_inc > L_MAX) ? L_MAX : w_spd_inc;
  assign w_floor    = !r_hit && (w_y_sum >= L_FLOOR);
  assign w_x_fp     = 32'(launchX) << SH;

  assign w_x_px   = r_x >>> SH;
  assign w_y_px   = r_y >>> SH;
  assign topLeftX = w_x_px[10:0];
  assign topLeftY = w_y_px[10:0];
  assign w_unused = ^{w_x_px[31:11], w_y_px[31:11]};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_spd   <= '0;
      r_hit   <= 1'b0;
      r_acc   <= 4'h0;
      r_cnt   <= '0;
      appear  <= 1'b0;
      busy    <= 1'b0;
      caught  <= 1'b0;
      missed  <= 1'b0;
    end else begin
      caught <= 1'b0;
      missed <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (launch) begin
            r_state <= FALL;
            r_x     <= w_x_fp;
            r_y     <= L_START;
            r_spd   <= L_INIT;
            r_hit   <= 1'b0;
            r_acc   <= 4'h0;
            appear  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FALL: begin
          if (startOfFrame) begin
            if (r_hit && w_vert) begin
              r_state <= HIT;
              r_cnt   <= '0;
              caught  <= 1'b1;
            end else if (w_floor) begin
              r_state <= IDLE;
              appear  <= 1'b0;
              busy    <= 1'b0;
              missed  <= 1'b1;
            end else begin
              r_y   <= w_y_sum;
              r_spd <= w_spd_sat;
              // Same-cycle collision belongs to the next frame.
              r_hit <= w_hit_now;
              r_acc <= w_hit_now ? HitEdgeCode : 4'h0;
            end
          end else if (w_hit_now) begin
            r_hit <= 1'b1;
            r_acc <= r_acc | HitEdgeCode;
          end
        end
        HIT: begin
          if (startOfFrame) begin
            if (r_cnt == L_LAST) begin
              r_state <= IDLE;
              appear  <= 1'b0;
              busy    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banana_motion_ctrl.sv
// Bench for banana_motion_ctrl: fixed vectors, corner sequences,
// and random traffic against a frame-level reference model.
module tb_banana_motion_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        sof = 1'b0;
  logic        launch = 1'b0;
  logic [10:0] lx = '0;
  logic        col = 1'b0;
  logic [3:0]  code = 4'h0;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        appear;
  logic        busy;
  logic        caught;
  logic        missed;

  banana_motion_ctrl dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(sof),
    .launch      (launch),
    .launchX     (lx),
    .collision   (col),
    .HitEdgeCode (code),
    .topLeftX    (topLeftX),
    .topLeftY    (topLeftY),
    .appear      (appear),
    .busy        (busy),
    .caught      (caught),
    .missed      (missed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_missed = 0;

  // Reference model: 0 idle, 1 falling, 2 showing a catch.
  int          m_mode;
  longint      m_y;
  longint      m_v;
  bit          m_hit;
  logic [3:0]  m_acc;
  int          m_left;
  logic [10:0] m_tlx;
  logic [10:0] m_tly;
  bit          m_c;
  bit          m_m;

  typedef struct {
    bit          s;
    bit          l;
    logic [10:0] x;
    bit          c;
    logic [3:0]  e;
    logic [10:0] tx;
    logic [10:0] ty;
    bit          ap;
    bit          bs;
    bit          ca;
    bit          mi;
  } vec_t;

  vec_t rows[9];

  function automatic logic [25:0] dut_vec();
    return {topLeftX, topLeftY, appear, busy, caught, missed};
  endfunction

  function automatic logic [25:0] mdl_vec();
    bit on;
    on = (m_mode != 0);
    return {m_tlx, m_tly, on, on, m_c, m_m};
  endfunction

  task automatic check(input string nm, input logic [25:0] act,
                       input logic [25:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_y = 0; m_v = 0; m_hit = 0; m_acc = 0;
    m_left = 0; m_tlx = 0; m_tly = 0; m_c = 0; m_m = 0;
  endtask

  task automatic model_step(input bit s, input bit l,
                            input logic [10:0] x, input bit c,
                            input logic [3:0] e);
    bit ended;
    m_c = 0;
    m_m = 0;
    if (m_mode == 0) begin
      if (l) begin
        m_mode = 1;
        m_tlx = x;
        m_y = 32 * 64;
        m_v = 40;
        m_tly = 11'd32;
        m_hit = 0;
        m_acc = 0;
      end
    end else if (m_mode == 1) begin
      if (s) begin
        if (m_hit && (m_acc[2] || m_acc[0])) begin
          m_mode = 2;
          m_left = 8;
          m_c = 1;
        end else begin
          ended = 0;
          if (m_hit) m_v = 0;
          else if (m_y + m_v >= 448 * 64) begin
            m_mode = 0;
            m_m = 1;
            ended = 1;
          end
          if (!ended) begin
            m_y = m_y + m_v;
            m_v = (m_v + 4 > 320) ? 320 : m_v + 4;
            m_tly = 11'(m_y / 64);
            m_hit = 0;
            m_acc = 0;
          end
        end
      end
      if (m_mode == 1 && c && e != 0) begin
        m_hit = 1;
        m_acc = m_acc | e;
      end
    end else if (s) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
  endtask

  task automatic cyc(input bit s, input bit l, input logic [10:0] x,
                     input bit c, input logic [3:0] e);
    sof = s; launch = l; lx = x; col = c; code = e;
    @(posedge clk);
    model_step(s, l, x, c, e);
    #1;
    check("model", dut_vec(), mdl_vec());
    if (missed) n_missed++;
    sof = 0; launch = 0; col = 0; code = 4'h0;
  endtask

  task automatic frame();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rows[0] = '{0, 1, 100, 0, 0, 100, 32, 1, 1, 0, 0};
    rows[1] = '{0, 0, 0, 0, 0, 100, 32, 1, 1, 0, 0};
    rows[2] = '{1, 0, 0, 0, 0, 100, 32, 1, 1, 0, 0};
    rows[3] = '{1, 0, 0, 0, 0, 100, 33, 1, 1, 0, 0};
    rows[4] = '{1, 0, 0, 0, 0, 100, 34, 1, 1, 0, 0};
    rows[5] = '{0, 0, 0, 1, 4, 100, 34, 1, 1, 0, 0};
    rows[6] = '{0, 0, 0, 0, 0, 100, 34, 1, 1, 0, 0};
    rows[7] = '{1, 0, 0, 0, 0, 100, 34, 1, 1, 1, 0};
    rows[8] = '{0, 0, 0, 0, 0, 100, 34, 1, 1, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_vec(), 26'd0);
    resetN = 1'b1;

    foreach (rows[i]) begin
      cyc(rows[i].s, rows[i].l, rows[i].x, rows[i].c, rows[i].e);
      check($sformatf("row%0d", i), dut_vec(),
            {rows[i].tx, rows[i].ty, rows[i].ap, rows[i].bs,
             rows[i].ca, rows[i].mi});
    end

    for (int f = 1; f <= 8; f++) begin
      cyc(1, 0, 0, 0, 0);
      check("hit_hold", {15'd0, topLeftY, appear, busy},
            {15'd0, 11'd34, f < 8, f < 8});
      cyc(0, 0, 0, 0, 0);
    end

    cyc(0, 1, 5, 0, 0);
    frame();
    cyc(0, 0, 0, 1, 8);
    cyc(1, 0, 0, 0, 0);
    check("side_frame", {15'd0, topLeftY, busy, caught},
          {15'd0, 11'd32, 1'b1, 1'b0});
    cyc(1, 0, 0, 0, 0);
    check("side_restart", {15'd0, topLeftY, busy, caught},
          {15'd0, 11'd32, 1'b1, 1'b0});
    frame();
    frame();
    cyc(1, 0, 0, 0, 0);
    check("side_later", {15'd0, topLeftY, busy, caught},
          {15'd0, 11'd33, 1'b1, 1'b0});

    n_missed = 0;
    for (int f = 0; f < 300 && busy; f++) begin
      if (f == 2) cyc(0, 1, 7, 0, 0);
      frame();
    end
    repeat (3) cyc(0, 0, 0, 0, 0);
    check("floor_state", {topLeftX, 13'd0, appear, busy},
          {11'd5, 13'd0, 1'b0, 1'b0});
    check("floor_pulses", 26'(n_missed), 26'd1);

    cyc(0, 1, 200, 0, 0);
    check("relaunch", {topLeftX, 13'd0, appear, busy},
          {11'd200, 13'd0, 1'b1, 1'b1});
    frame();
    frame();
    #2 resetN = 1'b0;
    #1;
    check("async_reset", dut_vec(), 26'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("reset_hold", dut_vec(), 26'd0);
    resetN = 1'b1;

    cyc(0, 1, 50, 0, 0);
    cyc(1, 0, 0, 1, 4);
    check("coinc_same", {24'd0, busy, caught}, {24'd0, 1'b1, 1'b0});
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("coinc_next", {24'd0, busy, caught}, {24'd0, 1'b1, 1'b1});

    for (int k = 0; k < 4000; k++) begin
      cyc($urandom_range(3) == 0, $urandom_range(15) == 0,
          11'($urandom_range(2047)), $urandom_range(5) == 0,
          4'($urandom_range(15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
